mem_responder: RTL and testbench

//  Memory-side responder for the pipeline's load/store and fetch initiators (IF, MA stages).
//  - Accepts word requests on a valid/ready channel and performs reads/writes on an internal 64-bit word array.
//  - Returns in-order responses on a second valid/ready channel after a fixed LATENCY.
//  - Tracks outstanding transactions with credits, so back-pressure never drops a response.

---
 rtl/mips64_mem_pkg.sv | 25 ++
 rtl/mem_responder_rsp_fifo.sv | 60 ++++++
 rtl/mem_responder.sv | 150 +++++++++++++++
 tb/tb_mem_responder.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips64_mem_pkg.sv
// Shared types and helpers for the memory responder.
// Response payload layout and the byte-strobe merge used on writes.
package mips64_mem_pkg;

  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } mem_rsp_t;

  // Replace only the bytes of old_w whose strobe bit is set.
  function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_responder_rsp_fifo.sv
// Response FIFO for mem_responder.
// Pointers carry one extra wrap bit, so full and empty are told apart
// without a separate count. Slot storage is not reset; only pointers are.
module rsp_fifo
  import mips64_mem_pkg::*;
#(
  parameter int RSP_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  mem_rsp_t din,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output mem_rsp_t dout
);

  localparam int AW = $clog2(RSP_DEPTH);
  localparam int PW = AW + 1;

  mem_rsp_t        slot_q [RSP_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

  // Full/empty flags and head-of-queue output from the registered pointers.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    dout  = slot_q[rd_ptr_q[AW-1:0]];
  end

  // Next pointer values; both wrap naturally through the extra MSB.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop && !empty) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Slot storage write.
  always_ff @(posedge clk) begin
    if (push && !full) slot_q[wr_ptr_q[AW-1:0]] <= din;
  end

  // Credits upstream guarantee a free slot for every push.
  no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory responder with a fixed-latency,
// in-order response path and credit-based request flow control.
// Optional feature: define MEM_BYTE_STROBE_EN to add req_wstrb and
// byte-granular writes; otherwise writes replace the whole word.
module mem_responder
  import mips64_mem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
`ifdef MEM_BYTE_STROBE_EN
  input  logic [7:0]        req_wstrb,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic [ADDR_W-4:0]  word_addr;
  logic [IDX_W-1:0]   word_idx;
  logic               addr_err;
  logic               accept;
  logic               pop;
  logic               mem_we;
  logic [STRB_W-1:0]  wstrb_eff;
  mem_rsp_t           rsp_new;

  logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  mem_rsp_t           pipe_rsp_q [LATENCY];
  mem_rsp_t           pipe_rsp_d [LATENCY];

  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic               ready_en_q, ready_en_d;

  logic               fifo_full;
  logic               fifo_empty;
  mem_rsp_t           fifo_dout;

`ifdef MEM_BYTE_STROBE_EN
  assign wstrb_eff = req_wstrb;
`else
  assign wstrb_eff = '1;
`endif

  // Request decode: word index, alignment/range error, handshake.
  always_comb begin
    word_addr = req_addr[ADDR_W-1:3];
    word_idx  = req_addr[3 +: IDX_W];
    addr_err  = (req_addr[2:0] != 3'b000) || ((word_addr >> IDX_W) != '0);
    accept    = req_valid && req_ready;
    mem_we    = accept && req_we && !addr_err;
  end

  // Response for the request being accepted; the read sees storage
  // before this edge's write, so a same-edge write is never observed.
  always_comb begin
    rsp_new.rdata = '0;
    rsp_new.err   = addr_err;
    if (!addr_err && !req_we) rsp_new.rdata = mem_q[word_idx];
  end

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[word_idx] <= strb_merge(mem_q[word_idx], req_wdata, wstrb_eff);
  end

  // Delay pipe shift: stage 0 captures at accept, last stage feeds the FIFO.
  always_comb begin
    pipe_vld_d[0] = accept;
    pipe_rsp_d[0] = rsp_new;
    for (int s = 1; s < LATENCY; s++) begin
      pipe_vld_d[s] = pipe_vld_q[s-1];
      pipe_rsp_d[s] = pipe_rsp_q[s-1];
    end
  end

  // Delay pipe valid bits; reset discards in-flight requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_vld_q <= '0;
    else        pipe_vld_q <= pipe_vld_d;
  end

  // Delay pipe payload (data only, qualified by the valid bits).
  always_ff @(posedge clk) begin
    for (int s = 0; s < LATENCY; s++) pipe_rsp_q[s] <= pipe_rsp_d[s];
  end

  rsp_fifo #(
    .RSP_DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pipe_vld_q[LATENCY-1]),
    .din   (pipe_rsp_q[LATENCY-1]),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  // Response channel; payload forced to zero whenever nothing is presented.
  always_comb begin
    rsp_valid = !fifo_empty;
    pop       = rsp_valid && rsp_ready;
    rsp_rdata = rsp_valid ? fifo_dout.rdata : '0;
    rsp_err   = rsp_valid ? fifo_dout.err   : 1'b0;
  end

  // Credit counter and ready enable next state.
  always_comb begin
    outstanding_d = outstanding_q;
    ready_en_d    = 1'b1;
    case ({accept, pop})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Credit and ready-enable registers; ready stays low until the first
  // clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      ready_en_q    <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      ready_en_q    <= ready_en_d;
    end
  end

  // Ready depends only on registered state.
  assign req_ready = ready_en_q && (outstanding_q < CNT_W'(RSP_DEPTH));

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed scenarios plus randomized traffic
// against a queue-based reference model. Build with MEM_BYTE_STROBE_EN
// defined to exercise byte strobes.
module tb_mem_responder;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 1024;
  localparam int LAT    = 2;
  localparam int RD     = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic [7:0]        req_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [63:0]       rsp_rdata;
  logic              rsp_err;

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .LATENCY   (LAT),
    .RSP_DEPTH (RD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef MEM_BYTE_STROBE_EN
    .req_wstrb (req_wstrb),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  typedef struct {
    logic [63:0] d;
    logic        e;
    logic        rd;
    int          n;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] mref [DEPTH];
  int          cyc = 0;
  int          since_rst = 0;
  int          last_hs = 0;
  int          acc_total = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [63:0] last_rdata = '0;

  int          mon_occ;
  int          mon_ev;
  logic        mon_vis;
  exp_t        mon_e;
  int          mon_idx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: every accept queues its expected response; a response
  // becomes visible LAT edges after its accept or one cycle after the
  // previous handshake, whichever is later.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      since_rst = 0;
      last_hs   = 0;
    end else begin
      since_rst++;
      mon_occ = exp_q.size();
      mon_vis = 1'b0;
      if (mon_occ > 0) begin
        mon_ev = exp_q[0].n + LAT;
        if (last_hs + 1 > mon_ev) mon_ev = last_hs + 1;
        mon_vis = (cyc >= mon_ev);
      end
      chk("rsp_valid", 64'(rsp_valid), 64'(mon_vis));
      if (rsp_valid && mon_occ > 0) begin
        chk("rsp_rdata", rsp_rdata, exp_q[0].d);
        chk("rsp_err", 64'(rsp_err), 64'(exp_q[0].e));
        if (rsp_ready) begin
          if (exp_q[0].rd) last_rdata = rsp_rdata;
          last_hs = cyc;
          void'(exp_q.pop_front());
        end
      end
      if (since_rst >= 2) chk("req_ready", 64'(req_ready), 64'(mon_occ < RD));
      if (req_valid && req_ready) begin
        mon_idx  = int'(req_addr >> 3);
        mon_e.n  = cyc + 1;
        mon_e.rd = 1'b0;
        mon_e.d  = '0;
        mon_e.e  = (req_addr[2:0] != 3'b000) || (mon_idx >= DEPTH);
        if (!mon_e.e) begin
          if (req_we) begin
            for (int b = 0; b < 8; b++) begin
`ifdef MEM_BYTE_STROBE_EN
              if (req_wstrb[b]) mref[mon_idx][8*b +: 8] = req_wdata[8*b +: 8];
`else
              mref[mon_idx][8*b +: 8] = req_wdata[8*b +: 8];
`endif
            end
          end else begin
            mon_e.d  = mref[mon_idx];
            mon_e.rd = 1'b1;
          end
        end
        exp_q.push_back(mon_e);
        acc_total++;
      end
    end
  end

  task automatic send(input logic we, input logic [31:0] addr, input logic [63:0] data,
                      input logic [7:0] strb);
    bit done;
    done      = 1'b0;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    req_wstrb = strb;
    req_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (req_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    chk("send_accepted", 64'(done), 64'd1);
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int k = 0; k < 500 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 64'd0);
    chk({tag, "_rsp_err"},   64'(rsp_err), 64'd0);
  endtask

  initial begin
    int a0;
    int target;
    int r;
    bit seen;
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int target;
    int r;
    bit seen;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = 8'hFF;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Known contents for the words used by random traffic.
    for (int w = 0; w < 64; w++) send(1'b1, 32'(w) << 3, {$urandom, $urandom}, 8'hFF);
    drain();

    // Write then read back on the next cycle.
    send(1'b1, 32'h40, 64'h0123_4567_89AB_CDEF, 8'hFF);
    send(1'b0, 32'h40, 64'h0, 8'hFF);
    drain();
    chk("t1_read", last_rdata, 64'h0123_4567_89AB_CDEF);

    // Misaligned and out-of-range reads; word 0 untouched.
    send(1'b1, 32'h0, 64'hA5A5_0000_FFFF_1234, 8'hFF);
    send(1'b0, 32'h44, 64'h0, 8'hFF);
    send(1'b1, 32'h2000, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF);
    send(1'b0, 32'h2000, 64'h0, 8'hFF);
    send(1'b0, 32'h0, 64'h0, 8'hFF);
    drain();
    chk("t2_word0", last_rdata, 64'hA5A5_0000_FFFF_1234);

    // Back-pressure: only RD requests accepted while responses are held.
    rsp_ready = 1'b0;
    a0        = acc_total;
    req_we    = 1'b0;
    req_addr  = 32'h8;
    req_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("full_accepts", 64'(acc_total - a0), 64'(RD));
    chk("full_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    drain();

    // Simultaneous accept and pop at three outstanding leaves three.
    rsp_ready = 1'b0;
    send(1'b0, 32'h10, 64'h0, 8'hFF);
    send(1'b0, 32'h18, 64'h0, 8'hFF);
    send(1'b0, 32'h20, 64'h0, 8'hFF);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("t4_rsp_seen", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h28;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("same_cycle_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    send(1'b0, 32'h30, 64'h0, 8'hFF);
    @(negedge clk);
    chk("credit_full", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    drain();

    // Randomized traffic with random back-pressure.
    target = acc_total + 1000;
    for (int k = 0; k < 20000 && acc_total < target; k++) begin
      req_valid = ($urandom_range(3) != 0);
      req_we    = 1'($urandom_range(1));
      r         = $urandom_range(15);
      if (r == 0)      req_addr = (32'($urandom_range(63)) << 3) | 32'($urandom_range(7, 1));
      else if (r == 1) req_addr = 32'($urandom_range(DEPTH + 200, DEPTH)) << 3;
      else             req_addr = 32'($urandom_range(63)) << 3;
      req_wdata = {$urandom, $urandom};
`ifdef MEM_BYTE_STROBE_EN
      req_wstrb = 8'($urandom);
`else
      req_wstrb = 8'hFF;
`endif
      rsp_ready = ($urandom_range(3) != 0);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    req_wstrb = 8'hFF;
    chk("rand_accepts", 64'(acc_total), 64'(target));
    drain();

    // Reset with requests in flight: responses discarded, storage kept.
    send(1'b1, 32'h48, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
    drain();
    rsp_ready = 1'b0;
    send(1'b0, 32'h48, 64'h0, 8'hFF);
    send(1'b0, 32'h50, 64'h0, 8'hFF);
    send(1'b0, 32'h58, 64'h0, 8'hFF);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    send(1'b0, 32'h48, 64'h0, 8'hFF);
    drain();
    chk("t5_retained", last_rdata, 64'hDEAD_BEEF_CAFE_F00D);

`ifdef MEM_BYTE_STROBE_EN
    // Byte strobes: partial write, then a zero-strobe no-op write.
    send(1'b1, 32'h28, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    send(1'b1, 32'h28, 64'h0, 8'h0F);
    send(1'b0, 32'h28, 64'h0, 8'hFF);
    drain();
    chk("strb_read", last_rdata, 64'hFFFF_FFFF_0000_0000);
    send(1'b1, 32'h28, 64'h0, 8'h00);
    send(1'b0, 32'h28, 64'h0, 8'hFF);
    drain();
    chk("strb_noop", last_rdata, 64'hFFFF_FFFF_0000_0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
